// File: rtl/rr_replay_unpacker_pkg.sv
// Shared constants, FSM state type and the prefix-sum offset helper for the replay unpacker.
package rr_replay_pkg;

    localparam int WIDTH                 = 1587;
    localparam int OFFSET_WIDTH          = 11;
    localparam int LOGB_CHANNEL_CNT      = 14;
    localparam int LOGE_CHANNEL_CNT      = 25;
    localparam int RR_CHANNEL_WIDTH_BITS = 10;
    localparam int MAX_CHANNEL_WIDTH     = 593;

    // Entry i is the payload width of channel i (sum = 1548).
    localparam logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS = {
        10'd100, 10'd50, 10'd70, 10'd100, 10'd48, 10'd32, 10'd64,
        10'd120, 10'd100, 10'd80, 10'd60, 10'd40, 10'd593, 10'd91
    };

    typedef enum logic [1:0] {IDLE, DECODE, ISSUE} state_e;

    typedef logic [OFFSET_WIDTH-1:0] off_t;
    typedef off_t [LOGB_CHANNEL_CNT:0] off_arr_t;

    // off[i] is where channel i's payload starts; off[LOGB_CHANNEL_CNT] is the packet length.
    function automatic off_arr_t get_offsets(input logic [LOGB_CHANNEL_CNT-1:0] bitmap);
        off_arr_t off;
        off[0] = off_t'(LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT);
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            off[i+1] = off[i] + (bitmap[i] ? off_t'(SHUFFLED_CHANNEL_WIDTHS[i]) : off_t'(0));
        end
        return off;
    endfunction

endpackage

// File: rtl/rr_replay_unpacker_if.sv
// Packet input and per-channel output bundle between the trace reader, unpacker and replay drivers.
interface rr_replay_unpacker_if;
    import rr_replay_pkg::*;

    logic                                                in_valid;
    logic                                                in_ready;
    logic [WIDTH-1:0]                                    in_pkt;
    logic [OFFSET_WIDTH-1:0]                             in_width;
    logic [LOGB_CHANNEL_CNT-1:0]                         ch_valid;
    logic [LOGB_CHANNEL_CNT-1:0]                         ch_ready;
    logic [LOGB_CHANNEL_CNT-1:0][MAX_CHANNEL_WIDTH-1:0]  ch_data;
    logic [LOGE_CHANNEL_CNT-1:0]                         loge_pending;
    logic [LOGE_CHANNEL_CNT-1:0]                         loge_done;

    modport master (
        output in_valid, in_pkt, in_width, ch_ready, loge_done,
        input  in_ready, ch_valid, ch_data, loge_pending
    );

    modport slave (
        input  in_valid, in_pkt, in_width, ch_ready, loge_done,
        output in_ready, ch_valid, ch_data, loge_pending
    );

endinterface

// File: rtl/rr_replay_slot_mux.sv
// Extracts one channel's payload pkt[off +: W] and zero-extends it to the common slot width.
module rr_replay_slot_mux
    import rr_replay_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic [WIDTH-1:0]             pkt,
    input  logic [OFFSET_WIDTH-1:0]      off,
    output logic [MAX_CHANNEL_WIDTH-1:0] data
);

    localparam logic [MAX_CHANNEL_WIDTH-1:0] MASK = {MAX_CHANNEL_WIDTH{1'b1}} >> (MAX_CHANNEL_WIDTH - W);

    assign data = MAX_CHANNEL_WIDTH'(pkt >> off) & MASK;

endmodule

// File: rtl/rr_replay_unpacker.sv
// Replay packet unpacker: latches a packet, computes channel offsets, then releases payloads and
// end-event barriers, accepting the next packet only once the current one has fully drained.
module rr_replay_unpacker
    import rr_replay_pkg::*;
(
    input  logic                 clk,
    input  logic                 sync_rst_n,
    rr_replay_unpacker_if.slave  bus,
    output logic [63:0]          pkt_count,
    output logic                 len_err
);

    state_e                                             state_q, state_d;
    logic [WIDTH-1:0]                                   pkt_q;
    logic [OFFSET_WIDTH-1:0]                            width_q;
    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0]      off_q;
    logic [LOGB_CHANNEL_CNT-1:0]                        pending_b;
    logic [LOGE_CHANNEL_CNT-1:0]                        loge_q;
    logic [LOGB_CHANNEL_CNT-1:0][MAX_CHANNEL_WIDTH-1:0] ch_data;
    off_arr_t                                           dec_off;
    logic                                               retire;

    assign dec_off          = get_offsets(pkt_q[LOGB_CHANNEL_CNT-1:0]);
    assign bus.loge_pending = loge_q;
    assign bus.ch_data      = ch_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.ch_valid = '0;
        retire       = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = sync_rst_n;
                if (bus.in_valid) state_d = DECODE;
            end
            DECODE: state_d = ISSUE;
            ISSUE: begin
                bus.ch_valid = pending_b;
                if (((pending_b & ~bus.ch_ready) == '0) && ((loge_q & ~bus.loge_done) == '0)) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the packet register is reset too, so every slot reads zero before the first packet.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            pkt_q     <= '0;
            width_q   <= '0;
            off_q     <= '0;
            pending_b <= '0;
            loge_q    <= '0;
            pkt_count <= '0;
            len_err   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        pkt_q   <= bus.in_pkt;
                        width_q <= bus.in_width;
                    end
                end
                DECODE: begin
                    off_q     <= dec_off[LOGB_CHANNEL_CNT-1:0];
                    pending_b <= pkt_q[LOGB_CHANNEL_CNT-1:0];
                    loge_q    <= pkt_q[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];
                    if (dec_off[LOGB_CHANNEL_CNT] > width_q) len_err <= 1'b1;
                end
                ISSUE: begin
                    pending_b <= pending_b & ~bus.ch_ready;
                    loge_q    <= loge_q & ~bus.loge_done;
                    if (retire) pkt_count <= pkt_count + 64'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_slot
        rr_replay_slot_mux #(
            .W (int'(SHUFFLED_CHANNEL_WIDTHS[i]))
        ) u_slot (
            .pkt  (pkt_q),
            .off  (off_q[i]),
            .data (ch_data[i])
        );
    end

endmodule
